// File: rtl/sa_input_skewer.sv
// sa_input_skewer: diagonal skew between the Im2Col vector unit and the systolic array.
// Lane k of each accepted vector reaches SA row k after k+1 cycles.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_start              frame start pulse (accepted in IDLE only)
//   i_vec_valid, i_vec   one LANES x DATA_W signed vector per cycle
//   i_last               marks the final vector of the frame
//   o_sa_row, o_sa_valid skewed operands and per-row valid
//   o_busy, o_done       frame in progress, one-cycle completion pulse
//   o_vec_count          vectors accepted in the current/last frame
//   o_err                sticky protocol error, cleared by accepted start
//
// Optional feature macro: SA_SKEW_BYPASS_EN adds i_bypass, which aligns all
// lanes to latency 1 for the frame and removes the drain phase.
module sa_input_skewer #(
    parameter int LANES  = 9,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic                           i_start,
    input  logic                           i_vec_valid,
    input  logic signed [LANES*DATA_W-1:0] i_vec,
    input  logic                           i_last,
`ifdef SA_SKEW_BYPASS_EN
    input  logic                           i_bypass,
`endif
    output logic signed [LANES*DATA_W-1:0] o_sa_row,
    output logic        [LANES-1:0]        o_sa_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic        [CNT_W-1:0]        o_vec_count,
    output logic                           o_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam int DW = $clog2(LANES);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(LANES - 1);

    logic [1:0]    state_q;
    logic [DW-1:0] drain_q;
    logic          byp_q;

    logic acc;
    logic start_ok;
    logic flush;
    logic err_evt;

    assign start_ok = (state_q == S_IDLE) && i_start;
    assign acc      = (state_q == S_STREAM) && i_vec_valid;
    assign flush    = start_ok;

    // Vector outside STREAM, start outside IDLE, or a stray i_last.
    assign err_evt  = (i_vec_valid && (state_q != S_STREAM))
                    || (i_start && (state_q != S_IDLE))
                    || (i_last && !i_vec_valid);

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DRAIN) && (drain_q == '0);

`ifdef SA_SKEW_BYPASS_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            byp_q <= 1'b0;
        end else if (start_ok) begin
            byp_q <= i_bypass;
        end
    end
`else
    assign byp_q = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            o_vec_count <= '0;
            o_err       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (i_vec_valid && i_last) begin
                        state_q <= S_DRAIN;
                        // Bypassed frames are already aligned: finish next cycle.
                        drain_q <= byp_q ? '0 : DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (start_ok) begin
                o_vec_count <= '0;
                o_err       <= err_evt;
            end else begin
                if (acc && (o_vec_count != '1)) begin
                    o_vec_count <= o_vec_count + CNT_W'(1);
                end
                o_err <= o_err | err_evt;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] d_q [k+1];
        logic        [k:0]        v_q;
        logic                     sel_v;
        logic signed [DATA_W-1:0] sel_d;

        // Chain shifts every cycle; idle slots carry zero data.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                v_q <= '0;
                for (int j = 0; j <= k; j++) begin
                    d_q[j] <= '0;
                end
            end else if (flush) begin
                v_q <= '0;
                for (int j = 0; j <= k; j++) begin
                    d_q[j] <= '0;
                end
            end else begin
                v_q[0] <= acc;
                d_q[0] <= acc ? i_vec[k*DATA_W +: DATA_W] : '0;
                for (int j = 1; j <= k; j++) begin
                    v_q[j] <= v_q[j-1];
                    d_q[j] <= d_q[j-1];
                end
            end
        end

        assign sel_v = byp_q ? v_q[0] : v_q[k];
        assign sel_d = byp_q ? d_q[0] : d_q[k];

        assign o_sa_valid[k] = sel_v;
        assign o_sa_row[k*DATA_W +: DATA_W] = sel_v ? sel_d : '0;
    end

endmodule

// File: tb/tb_sa_input_skewer.sv
// tb_sa_input_skewer: scoreboard bench for sa_input_skewer.
// Stimulus pushes per-lane expectations; a negedge monitor pops and compares.
module tb_sa_input_skewer;

    localparam int LANES = 9;
    localparam int DW    = 8;
    localparam int CW    = 16;

    logic                  i_clk = 1'b0;
    logic                  i_rstn;
    logic                  i_start;
    logic                  i_vec_valid;
    logic [LANES*DW-1:0]   i_vec;
    logic                  i_last;
`ifdef SA_SKEW_BYPASS_EN
    logic                  i_bypass;
`endif
    logic [LANES*DW-1:0]   o_sa_row;
    logic [LANES-1:0]      o_sa_valid;
    logic                  o_busy;
    logic                  o_done;
    logic [CW-1:0]         o_vec_count;
    logic                  o_err;

    always #5 i_clk = ~i_clk;

    sa_input_skewer #(
        .LANES (LANES),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_start    (i_start),
        .i_vec_valid(i_vec_valid),
        .i_vec      (i_vec),
        .i_last     (i_last),
`ifdef SA_SKEW_BYPASS_EN
        .i_bypass   (i_bypass),
`endif
        .o_sa_row   (o_sa_row),
        .o_sa_valid (o_sa_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_vec_count(o_vec_count),
        .o_err      (o_err)
    );

    typedef struct {
        int          c;
        logic [DW-1:0] d;
    } exp_t;

    exp_t lq [LANES][$];
    int   dq [$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   byp    = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        int   dc;
        for (int k = 0; k < LANES; k++) begin
            if (o_sa_valid[k]) begin
                if (lq[k].size() == 0) begin
                    chk($sformatf("row%0d_unexpected", k), 1, 0);
                end else begin
                    e = lq[k].pop_front();
                    chk($sformatf("row%0d_data", k), o_sa_row[k*DW +: DW], e.d);
                    chk($sformatf("row%0d_cycle", k), cyc, e.c);
                end
            end else if (o_sa_row[k*DW +: DW] != '0) begin
                chk($sformatf("row%0d_zero", k), o_sa_row[k*DW +: DW], 0);
            end
        end
        if (o_done) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                dc = dq.pop_front();
                chk("done_cycle", cyc, dc);
            end
        end
    end

    task automatic drive_zero();
        i_start     = 1'b0;
        i_vec_valid = 1'b0;
        i_last      = 1'b0;
        i_vec       = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            drive_zero();
        end
    endtask

    task automatic start();
        @(posedge i_clk);
        #1;
        drive_zero();
        i_start = 1'b1;
    endtask

    // Lane k value = base + step*k; accepted vectors push expectations.
    task automatic send(input int base, input int step, input bit last,
                        input bit accept, input bit st);
        @(posedge i_clk);
        #1;
        i_start     = st;
        i_vec_valid = 1'b1;
        i_last      = last;
        for (int k = 0; k < LANES; k++) begin
            i_vec[k*DW +: DW] = DW'(base + step * k);
        end
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                lq[k].push_back('{c: cyc + 1 + (byp ? 0 : k), d: DW'(base + step * k)});
            end
            if (last) dq.push_back(cyc + 1 + (byp ? 0 : LANES - 1));
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while (o_busy && b < 50) begin
            @(posedge i_clk);
            #1;
            b++;
        end
        chk("idle_timeout", o_busy, 0);
    endtask

    initial begin
        i_rstn = 1'b0;
        drive_zero();
`ifdef SA_SKEW_BYPASS_EN
        i_bypass = 1'b0;
`endif
        #12;
        chk("rst_count", o_vec_count, 0);
        chk("rst_err", o_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valid", o_sa_valid, 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Single vector, rows 1..9
        start();
        send(1, 1, 1, 1, 0);
        idle(1);
        chk("single_busy", o_busy, 1);
        wait_idle();
        chk("single_count", o_vec_count, 1);
        chk("single_err", o_err, 0);
        idle(2);

        // Burst of 10 back-to-back vectors
        start();
        for (int v = 0; v < 10; v++) send(10 * v, 1, v == 9, 1, 0);
        idle(1);
        wait_idle();
        chk("burst_count", o_vec_count, 10);
        idle(2);

        // Bubble between two vectors, negative data first
        start();
        send(-1, -1, 0, 1, 0);
        idle(1);
        send(50, 1, 1, 1, 0);
        idle(1);
        wait_idle();
        chk("bubble_count", o_vec_count, 2);
        chk("bubble_err", o_err, 0);
        idle(2);

        // Protocol errors
        send(7, 1, 0, 0, 0);
        idle(1);
        chk("idle_vec_err", o_err, 1);
        chk("idle_vec_count", o_vec_count, 2);
        chk("idle_vec_busy", o_busy, 0);
        start();
        idle(1);
        chk("start_clr_err", o_err, 0);
        chk("start_busy", o_busy, 1);
        chk("start_clr_count", o_vec_count, 0);
        send(20, 1, 0, 1, 0);
        send(30, 1, 0, 1, 1);
        send(40, 1, 1, 1, 0);
        idle(1);
        chk("mid_start_err", o_err, 1);
        wait_idle();
        chk("err_frame_count", o_vec_count, 3);
        chk("err_sticky", o_err, 1);
        start();
        idle(1);
        chk("restart_clr_err", o_err, 0);
        send(60, 1, 1, 1, 0);
        idle(1);
        wait_idle();
        idle(1);
        @(posedge i_clk);
        #1;
        i_last = 1'b1;
        idle(1);
        chk("stray_last_err", o_err, 1);
        idle(1);

        // Reset mid-frame
        start();
        send(70, 1, 0, 1, 0);
        send(80, 1, 0, 1, 0);
        send(90, 1, 0, 1, 0);
        idle(1);
        #1;
        i_rstn = 1'b0;
        for (int k = 0; k < LANES; k++) lq[k].delete();
        dq.delete();
        #1;
        chk("mrst_valid", o_sa_valid, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_count", o_vec_count, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_err", o_err, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        idle(12);
        chk("mrst_still_idle", o_busy, 0);

`ifdef SA_SKEW_BYPASS_EN
        // Bypass frame: all rows aligned, no drain
        i_bypass = 1'b1;
        byp = 1'b1;
        start();
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_bypass = 1'b0;
        send(5, 2, 0, 1, 0);
        send(-20, 3, 0, 1, 0);
        send(100, -1, 1, 1, 0);
        idle(1);
        wait_idle();
        chk("byp_count", o_vec_count, 3);
        byp = 1'b0;
        idle(2);
`endif

        idle(3);
        for (int k = 0; k < LANES; k++) begin
            chk($sformatf("row%0d_leftover", k), lq[k].size(), 0);
        end
        chk("done_leftover", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
